lmsm_sequencer: RTL and testbench
=================================

Name: lmsm_sequencer

Overview:
Expands a decoded LM/SM instruction into one single-register memory micro-op per set bit of its 8-bit register mask, lowest register first. Micro-ops issue in consecutive cycles with consecutive word offsets from the base held in regA. The block sits between decode and register-read. While it is busy it stalls fetch/decode, so the downstream forwarding logic only ever sees single-register LW/SW-like operations, each carrying its destination/source register in the regA field.

Parameters:
NREG, 8, number of architectural registers; also the mask width.
REGW, 3, register index width; equals log2(NREG).
OPW, 6, opcode field width passed through to the micro-op.

Ports:
clk  in  1  pipeline clock.
reset_n  in  1  asynchronous active-low reset.
id_valid  in  1  decode stage holds a valid instruction.
id_op  in  OPW  decoded opcode; bits [5:2] give the major opcode (LM=4'b0110, SM=4'b0111).
id_regA  in  REGW  base-address register index.
id_mask  in  NREG  register list; bit i selects Ri.
hold  in  1  downstream stall; freezes the block.
flush  in  1  pipeline flush (branch/jump redirect).
busy  out  1  stall request to fetch/decode.
uop_valid  out  1  micro-op valid this cycle.
uop_op  out  OPW  copy of the LM/SM opcode.
uop_base  out  REGW  base register index (latched id_regA).
uop_reg  out  REGW  register loaded or stored by this micro-op.
uop_offset  out  REGW  word offset from base; 0 for the first micro-op, incrementing by 1.
uop_last  out  1  final micro-op of the sequence.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; busy, uop_valid and uop_last =0; uop_op, uop_base, uop_reg and uop_offset =0; internal mask and counter cleared.
- States: IDLE and SEQ.
- Accept: in IDLE with id_valid=1, id_op[5:2] in {LM,SM}, hold=0 and flush=0, latch op, regA and mask.
  - Nonzero mask: go to SEQ.
  - Zero mask: stay IDLE and emit nothing.
  - Non-LM/SM opcodes are ignored.
- busy is combinational: 1 when state=SEQ, or when IDLE is accepting an LM/SM with a nonzero mask. Decode must hold the instruction while busy=1.
- SEQ, each cycle with hold=0:
  - uop_valid=1 and uop_reg = index of the lowest set bit of the remaining mask.
  - uop_offset = count of micro-ops already issued in this sequence.
  - Clear that bit from the remaining mask and increment the offset (3-bit, cannot wrap within 8 bits).
  - uop_last=1 when that was the only remaining bit; go to IDLE on the next edge.
- Latency: the first micro-op appears the cycle after accept. A mask with k set bits yields exactly k consecutive micro-op cycles when hold=0.
- busy deasserts in the cycle uop_last=1 (combinationally). Decode may therefore present the next instruction, which is accepted on that same edge: back-to-back LM/SM with zero bubble.
- hold=1: all registers and outputs frozen, and uop_valid is held at its current value. Downstream must ignore uop_valid while hold=1.
- flush=1 (any state): next state=IDLE, remaining mask cleared, uop_valid=0 the next cycle. flush has priority over hold and accept.
- Simultaneous flush and last micro-op: the flush wins and no further micro-ops issue.
- reset_n asserted mid-sequence: immediate return to the reset values; the partial sequence is discarded.

Optional Feature:
LMSM_ZERO_MASK_TRAP_EN: adds output zero_mask_err (1 bit).
- When defined: an accepted LM/SM with mask 0 pulses zero_mask_err=1 for one cycle on the following cycle; the instruction still produces no micro-ops.
- When undefined: the port and its logic are absent, and a zero mask is a silent NOP.

Decomposition:
- Shared package lmsm_pkg:
  - Opcode constants LM, SM, LW and SW (4-bit major).
  - NREG/REGW defaults.
  - State enum {IDLE, SEQ}.
  - Constants reused by the forwarding and hazard units.
- One natural sub-module: lowest_set_bit_enc (NREG-bit priority encoder returning index plus a one-hot clear mask).

Test Plan:
1. LM, regA=R5, mask=8'b1010_0101, no hold -> 4 micro-ops on cycles 1-4:
   - uop_reg = 0, 2, 5, 7
   - uop_offset = 0, 1, 2, 3
   - uop_last=1 only on the 4th; busy=1 on cycles 0-3, 0 on cycle 4.
2. SM mask=8'hFF -> 8 micro-ops with uop_reg=offset=0..7; the following LM accepted in the uop_last cycle issues its first micro-op the next cycle.
3. LM mask=8'b0001_0010, hold=1 asserted for 3 cycles after the first micro-op -> outputs frozen (uop_reg=1, offset=0) for those cycles, then uop_reg=4, offset=1, last=1.
4. flush pulsed on the 2nd micro-op of mask 8'b0000_1111 -> uop_valid=0 next cycle, busy=0, state IDLE; no further micro-ops.
5. LM mask=0 -> busy never asserts, no uop_valid; with LMSM_ZERO_MASK_TRAP_EN defined, zero_mask_err=1 for exactly one cycle.
6. reset_n driven low asynchronously mid-sequence -> all outputs 0 immediately; after release, IDLE accepts a new LM normally.

Source files
------------

// File: rtl/lmsm_pkg.sv
// Shared LM/SM definitions: major opcodes, register-file geometry and sequencer states.
// Also used by the forwarding and hazard units that consume the expanded micro-ops.
package lmsm_pkg;

  localparam int NREG_DEF = 8;
  localparam int REGW_DEF = 3;
  localparam int OPW_DEF  = 6;

  // Major opcodes live in id_op[5:2]
  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  function automatic logic is_lmsm(input logic [3:0] major);
    return (major == OP_LM) || (major == OP_SM);
  endfunction

endpackage

// File: rtl/lowest_set_bit_enc.sv
// Priority encoder: index of the lowest set bit plus its one-hot mask (zero input gives 0/0).
// Purely combinational; no backpressure.
module lowest_set_bit_enc #(
  parameter int NREG = 8,
  parameter int REGW = 3
) (
  input  logic [NREG-1:0] vec,
  output logic [REGW-1:0] idx,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    // Two's complement isolates the lowest set bit
    onehot = vec & (~vec + NREG'(1));
    idx    = '0;
    for (int i = 0; i < NREG; i++) begin
      if (onehot[i]) idx = REGW'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM expander: one single-register micro-op per mask bit, lowest first, first one the cycle after accept.
// hold freezes everything, flush beats hold/accept; LMSM_ZERO_MASK_TRAP_EN adds the zero_mask_err pulse.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int REGW = REGW_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_op,
  input  logic [REGW-1:0] id_regA,
  input  logic [NREG-1:0] id_mask,
  input  logic            hold,
  input  logic            flush,
  output logic            busy,
  output logic            uop_valid,
  output logic [OPW-1:0]  uop_op,
  output logic [REGW-1:0] uop_base,
  output logic [REGW-1:0] uop_reg,
  output logic [REGW-1:0] uop_offset,
  output logic            uop_last
`ifdef LMSM_ZERO_MASK_TRAP_EN
  ,
  output logic            zero_mask_err
`endif
);

  logic [0:0]      state;
  logic [NREG-1:0] mask_q;
  logic [REGW-1:0] cnt_q;

  logic            in_seq;
  logic            accept_raw;
  logic            accept_nz;
  logic [NREG-1:0] enc_src;
  logic [NREG-1:0] enc_onehot;
  logic [REGW-1:0] enc_idx;
  logic [NREG-1:0] rem_next;
  logic            rem_zero;
  logic [REGW-1:0] cur_off;

  assign in_seq     = (state == SEQ);
  assign accept_raw = (state == IDLE) && id_valid && is_lmsm(id_op[OPW-1:OPW-4]) && !hold && !flush;
  assign accept_nz  = accept_raw && (|id_mask);
  assign busy       = in_seq || accept_nz;

  // The accept cycle encodes straight from decode so the first micro-op costs no extra cycle
  assign enc_src  = in_seq ? mask_q : id_mask;
  assign rem_next = enc_src & ~enc_onehot;
  assign rem_zero = (rem_next == '0);
  assign cur_off  = in_seq ? cnt_q : '0;

  lowest_set_bit_enc #(
    .NREG (NREG),
    .REGW (REGW)
  ) u_enc (
    .vec    (enc_src),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mask_q     <= '0;
      cnt_q      <= '0;
      uop_valid  <= 1'b0;
      uop_last   <= 1'b0;
      uop_op     <= '0;
      uop_base   <= '0;
      uop_reg    <= '0;
      uop_offset <= '0;
    end else if (flush) begin
      state     <= IDLE;
      mask_q    <= '0;
      cnt_q     <= '0;
      uop_valid <= 1'b0;
      uop_last  <= 1'b0;
    end else if (!hold) begin
      if (in_seq || accept_nz) begin
        if (!in_seq) begin
          uop_op   <= id_op;
          uop_base <= id_regA;
        end
        uop_valid  <= 1'b1;
        uop_reg    <= enc_idx;
        uop_offset <= cur_off;
        cnt_q      <= cur_off + REGW'(1);
        mask_q     <= rem_next;
        uop_last   <= rem_zero;
        state      <= rem_zero ? IDLE : SEQ;
      end else begin
        uop_valid <= 1'b0;
        uop_last  <= 1'b0;
      end
    end
  end

`ifdef LMSM_ZERO_MASK_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_mask_err <= 1'b0;
    end else if (flush) begin
      zero_mask_err <= 1'b0;
    end else if (!hold) begin
      zero_mask_err <= accept_raw && (id_mask == '0);
    end
  end
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: hand-derived per-cycle expectations for each scenario.
// Define LMSM_ZERO_MASK_TRAP_EN to also cover the zero-mask error pulse.
module tb_lmsm_sequencer;

  localparam logic [5:0] LM_OP = 6'b011000;
  localparam logic [5:0] SM_OP = 6'b011100;
  localparam logic [5:0] LW_OP = 6'b010000;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [5:0] id_op;
  logic [2:0] id_regA;
  logic [7:0] id_mask;
  logic       hold;
  logic       flush;
  logic       busy;
  logic       uop_valid;
  logic [5:0] uop_op;
  logic [2:0] uop_base;
  logic [2:0] uop_reg;
  logic [2:0] uop_offset;
  logic       uop_last;
`ifdef LMSM_ZERO_MASK_TRAP_EN
  logic       zero_mask_err;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [8:0]  obs;
  logic [17:0] all_out;
  assign obs     = {busy, uop_valid, uop_last, uop_reg, uop_offset};
  assign all_out = {busy, uop_valid, uop_last, uop_op, uop_base, uop_reg, uop_offset};

  lmsm_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_valid   (id_valid),
    .id_op      (id_op),
    .id_regA    (id_regA),
    .id_mask    (id_mask),
    .hold       (hold),
    .flush      (flush),
    .busy       (busy),
    .uop_valid  (uop_valid),
    .uop_op     (uop_op),
    .uop_base   (uop_base),
    .uop_reg    (uop_reg),
    .uop_offset (uop_offset),
    .uop_last   (uop_last)
`ifdef LMSM_ZERO_MASK_TRAP_EN
    ,
    .zero_mask_err (zero_mask_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; id_valid = 1'b0; id_op = '0; id_regA = '0; id_mask = '0;
    hold = 1'b0; flush = 1'b0;
    #3;
    if (all_out !== 18'd0) begin
      $display("FAIL reset_outputs got %h want %h", all_out, 18'd0); nerr++;
    end
    nvec++;
    #9;
    reset_n = 1'b1;
    tick();
  endtask

  // Observed word is {busy, valid, last, reg[2:0], offset[2:0]}
  task automatic test_lm_basic;
    logic [8:0] want [6];
    logic [8:0] care;
    want = '{9'b1_0_0_000_000, 9'b1_1_0_000_000, 9'b1_1_0_010_001,
             9'b1_1_0_101_010, 9'b0_1_1_111_011, 9'b0_0_0_000_000};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        id_valid = 1'b1; id_op = LM_OP; id_regA = 3'd5; id_mask = 8'b1010_0101;
      end else id_valid = 1'b0;
      #1;
      care = (c == 5) ? 9'b111_000_000 : 9'h1FF;
      if ((obs & care) !== (want[c] & care)) begin
        $display("FAIL lm_basic c%0d got %b want %b", c, obs & care, want[c] & care); nerr++;
      end
      nvec++;
      if (c == 1) begin
        if ({uop_op, uop_base} !== {LM_OP, 3'd5}) begin
          $display("FAIL lm_basic_opbase got %h want %h", {uop_op, uop_base}, {LM_OP, 3'd5}); nerr++;
        end
        nvec++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] want;
    logic [8:0] care;
    for (int c = 0; c < 12; c++) begin
      care = 9'h1FF;
      id_valid = 1'b0;
      if (c == 0) begin
        id_valid = 1'b1; id_op = SM_OP; id_regA = 3'd2; id_mask = 8'hFF;
        want = 9'b1_0_0_000_000; care = 9'b110_000_000;
      end else if (c <= 7) begin
        want = {1'b1, 1'b1, 1'b0, 3'(c - 1), 3'(c - 1)};
      end else if (c == 8) begin
        id_valid = 1'b1; id_op = LM_OP; id_regA = 3'd3; id_mask = 8'b0000_0110;
        want = 9'b1_1_1_111_111;
      end else if (c == 9) begin
        want = 9'b1_1_0_001_000;
      end else if (c == 10) begin
        want = 9'b0_1_1_010_001;
      end else begin
        want = 9'b0_0_0_000_000; care = 9'b110_000_000;
      end
      #1;
      if ((obs & care) !== (want & care)) begin
        $display("FAIL back_to_back c%0d got %b want %b", c, obs & care, want & care); nerr++;
      end
      nvec++;
      if (c == 8 || c == 9) begin
        if ({uop_op, uop_base} !== ((c == 8) ? {SM_OP, 3'd2} : {LM_OP, 3'd3})) begin
          $display("FAIL back_to_back_opbase c%0d got %h want %h", c, {uop_op, uop_base},
                   (c == 8) ? {SM_OP, 3'd2} : {LM_OP, 3'd3});
          nerr++;
        end
        nvec++;
      end
      tick();
    end
  endtask

  task automatic test_hold;
    logic [8:0] want [7];
    logic [8:0] care;
    want = '{9'b1_0_0_000_000, 9'b1_1_0_001_000, 9'b1_1_0_001_000, 9'b1_1_0_001_000,
             9'b1_1_0_001_000, 9'b0_1_1_100_001, 9'b0_0_0_000_000};
    for (int c = 0; c < 7; c++) begin
      id_valid = (c == 0);
      id_op = LM_OP; id_regA = 3'd1; id_mask = 8'b0001_0010;
      hold = (c >= 1 && c <= 3);
      #1;
      care = (c == 0 || c == 6) ? 9'b110_000_000 : 9'h1FF;
      if ((obs & care) !== (want[c] & care)) begin
        $display("FAIL hold c%0d got %b want %b", c, obs & care, want[c] & care); nerr++;
      end
      nvec++;
      tick();
    end
    hold = 1'b0;
  endtask

  task automatic test_flush;
    logic [8:0] want [8];
    logic [8:0] care;
    want = '{9'b1_0_0_000_000, 9'b1_1_0_000_000, 9'b1_1_0_001_001, 9'b0_0_0_000_000,
             9'b0_0_0_000_000, 9'b0_0_0_000_000, 9'b0_0_0_000_000, 9'b0_0_0_000_000};
    for (int c = 0; c < 8; c++) begin
      id_valid = (c == 0 || c == 6);
      id_op = LM_OP; id_regA = 3'd0; id_mask = 8'b0000_1111;
      flush = (c == 2 || c == 6);
      #1;
      care = (c == 1 || c == 2) ? 9'h1FF : 9'b111_000_000;
      if ((obs & care) !== (want[c] & care)) begin
        $display("FAIL flush c%0d got %b want %b", c, obs & care, want[c] & care); nerr++;
      end
      nvec++;
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_zero_mask;
    for (int c = 0; c < 7; c++) begin
      id_valid = (c == 0 || c == 4);
      id_op    = (c == 4) ? LW_OP : LM_OP;
      id_mask  = (c == 4) ? 8'hFF : 8'h00;
      id_regA  = 3'd7;
      #1;
      if ({busy, uop_valid} !== 2'b00) begin
        $display("FAIL zero_mask c%0d busy_valid got %b want %b", c, {busy, uop_valid}, 2'b00); nerr++;
      end
      nvec++;
`ifdef LMSM_ZERO_MASK_TRAP_EN
      if (zero_mask_err !== (c == 1)) begin
        $display("FAIL zero_mask_err c%0d got %b want %b", c, zero_mask_err, (c == 1)); nerr++;
      end
      nvec++;
`endif
      tick();
    end
  endtask

  task automatic test_async_reset;
    logic [8:0] want [3];
    logic [8:0] care;
    for (int c = 0; c < 3; c++) begin
      id_valid = (c == 0); id_op = SM_OP; id_regA = 3'd4; id_mask = 8'hFF;
      #1;
      if (c == 2 && obs !== 9'b1_1_0_001_001) begin
        $display("FAIL async_pre c%0d got %b want %b", c, obs, 9'b1_1_0_001_001); nerr++;
      end
      if (c == 2) nvec++;
      if (c < 2) tick();
    end
    reset_n = 1'b0;
    #1;
    if (all_out !== 18'd0) begin
      $display("FAIL async_reset got %h want %h", all_out, 18'd0); nerr++;
    end
    nvec++;
    #2;
    reset_n = 1'b1;
    tick();
    want = '{9'b1_0_0_000_000, 9'b0_1_1_111_000, 9'b0_0_0_000_000};
    for (int c = 0; c < 3; c++) begin
      id_valid = (c == 0); id_op = LM_OP; id_regA = 3'd6; id_mask = 8'b1000_0000;
      #1;
      care = (c == 1) ? 9'h1FF : 9'b111_000_000;
      if ((obs & care) !== (want[c] & care)) begin
        $display("FAIL async_after c%0d got %b want %b", c, obs & care, want[c] & care); nerr++;
      end
      nvec++;
      if (c == 1) begin
        if (uop_base !== 3'd6) begin
          $display("FAIL async_after_base got %0d want %0d", uop_base, 6); nerr++;
        end
        nvec++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_back_to_back();
    test_hold();
    test_flush();
    test_zero_mask();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
